// File: rtl/issue_queue.sv
// 16-entry issue queue: holds dispatched uops, tracks two source tags via result-bus wakeup,
// and presents a per-slot ready vector and packed dest tags to the selector.
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_src1,
    input  logic                       in_src1_rdy,
    input  logic [TAG_W-1:0]           in_src2,
    input  logic                       in_src2_rdy,
    input  logic [TAG_W-1:0]           in_dest,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    output logic [DEPTH-1:0]           ready_vec,
    output logic [DEPTH*TAG_W-1:0]     addr_vec,
    input  logic                       issue_valid,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       issue_miss,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_s1rdy;
    logic [DEPTH-1:0] r_s2rdy;
    logic [TAG_W-1:0] r_src1 [DEPTH];
    logic [TAG_W-1:0] r_src2 [DEPTH];
    logic [TAG_W-1:0] r_dest [DEPTH];
    logic             r_miss;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_iss_hit;
    logic [CNT_W-1:0] w_count;
    logic [IDX_W-1:0] w_alloc_idx;
    logic             w_found;
    logic             w_accept;
    logic             w_new_s1rdy;
    logic             w_new_s2rdy;

    always_comb begin
        w_ready   = '0;
        w_iss_hit = '0;
        w_count   = '0;
        addr_vec  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ready[i]   = r_valid[i] & r_s1rdy[i] & r_s2rdy[i];
            w_iss_hit[i] = issue_valid & w_ready[i] & (r_dest[i] == issue_tag);
            w_count      = w_count + CNT_W'(r_valid[i]);
            if (r_valid[i])
                addr_vec[i*TAG_W +: TAG_W] = r_dest[i];
        end
    end

    // Lowest free slot from the registered valid view; slots freed this cycle are not reused yet.
    always_comb begin
        w_alloc_idx = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_found) begin
                w_alloc_idx = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    assign ready_vec  = w_ready;
    assign count      = w_count;
    assign in_ready   = (w_count < CNT_W'(DEPTH));
    assign issue_miss = r_miss;
    assign w_accept   = in_valid & in_ready;

    // Same-cycle wakeup bypass so a writeback coincident with dispatch is not lost.
    assign w_new_s1rdy = in_src1_rdy | (in_src1 == '0) | (wb_valid & (wb_tag == in_src1));
    assign w_new_s2rdy = in_src2_rdy | (in_src2 == '0) | (wb_valid & (wb_tag == in_src2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_s1rdy <= '0;
            r_s2rdy <= '0;
            r_miss  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_src1[i] <= '0;
                r_src2[i] <= '0;
                r_dest[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wb_valid && (r_src1[i] == wb_tag))
                    r_s1rdy[i] <= 1'b1;
                if (wb_valid && (r_src2[i] == wb_tag))
                    r_s2rdy[i] <= 1'b1;
                if (w_iss_hit[i])
                    r_valid[i] <= 1'b0;
            end
            if (w_accept) begin
                r_valid[w_alloc_idx] <= 1'b1;
                r_src1[w_alloc_idx]  <= in_src1;
                r_src2[w_alloc_idx]  <= in_src2;
                r_dest[w_alloc_idx]  <= in_dest;
                r_s1rdy[w_alloc_idx] <= w_new_s1rdy;
                r_s2rdy[w_alloc_idx] <= w_new_s2rdy;
            end
            r_miss <= issue_valid & ~(|w_iss_hit);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Table-driven directed bench for issue_queue: each record is one cycle of stimulus and the
// outputs expected right after that clock edge, plus hand checks of the packed dest tags.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [4:0]  in_src1, in_src2, in_dest, wb_tag, issue_tag;
    logic        in_src1_rdy, in_src2_rdy, wb_valid, issue_valid, issue_miss;
    logic [15:0] ready_vec;
    logic [79:0] addr_vec;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    issue_queue #(.DEPTH(16), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src1_rdy(in_src1_rdy),
        .in_src2(in_src2), .in_src2_rdy(in_src2_rdy),
        .in_dest(in_dest),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .ready_vec(ready_vec), .addr_vec(addr_vec),
        .issue_valid(issue_valid), .issue_tag(issue_tag),
        .issue_miss(issue_miss), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [4:0]  s1;
        logic        s1r;
        logic [4:0]  s2;
        logic        s2r;
        logic [4:0]  dst;
        logic        wbv;
        logic [4:0]  wbt;
        logic        isv;
        logic [4:0]  ist;
        logic [15:0] e_rv;
        logic [4:0]  e_cnt;
        logic        e_ir;
        logic        e_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic iv, logic [4:0] s1, logic s1r,
                                logic [4:0] s2, logic s2r, logic [4:0] dst, logic wbv,
                                logic [4:0] wbt, logic isv, logic [4:0] ist, logic [15:0] erv,
                                logic [4:0] ecnt, logic eir, logic emiss);
        vec_t v;
        v.name = n; v.rst = r; v.iv = iv; v.s1 = s1; v.s1r = s1r; v.s2 = s2; v.s2r = s2r;
        v.dst = dst; v.wbv = wbv; v.wbt = wbt; v.isv = isv; v.ist = ist;
        v.e_rv = erv; v.e_cnt = ecnt; v.e_ir = eir; v.e_miss = emiss;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic apply(vec_t v);
        rst = v.rst; in_valid = v.iv;
        in_src1 = v.s1; in_src1_rdy = v.s1r; in_src2 = v.s2; in_src2_rdy = v.s2r;
        in_dest = v.dst; wb_valid = v.wbv; wb_tag = v.wbt;
        issue_valid = v.isv; issue_tag = v.ist;
        @(posedge clk);
        #1;
        chk({v.name, ".ready_vec"}, 32'(ready_vec), 32'(v.e_rv));
        chk({v.name, ".count"}, 32'(count), 32'(v.e_cnt));
        chk({v.name, ".in_ready"}, 32'(in_ready), 32'(v.e_ir));
        chk({v.name, ".issue_miss"}, 32'(issue_miss), 32'(v.e_miss));
    endtask

    task automatic run_table();
        for (int k = 0; k < vecs.size(); k++)
            apply(vecs[k]);
        vecs.delete();
    endtask

    function automatic logic [4:0] slot_addr(int i);
        return addr_vec[i*5 +: 5];
    endfunction

    initial begin
        logic [16:0] rv;
        rst = 1'b1; in_valid = 1'b0; in_src1 = '0; in_src1_rdy = 1'b0; in_src2 = '0;
        in_src2_rdy = 1'b0; in_dest = '0; wb_valid = 1'b0; wb_tag = '0;
        issue_valid = 1'b0; issue_tag = '0;

        // Reset, then fill all 16 slots with fully ready uops, dest = (8+i) mod 32.
        vecs.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
        for (int k = 1; k <= 16; k++) begin
            rv = (17'd1 << k) - 17'd1;
            vecs.push_back(mk($sformatf("fill%0d", k), 0, 1, 5'd1, 1, 5'd2, 1, 5'((8 + k - 1) % 32),
                              0, 0, 0, 0, rv[15:0], 5'(k), (k < 16), 0));
        end
        vecs.push_back(mk("full_reject", 0, 1, 1, 1, 2, 1, 25, 0, 0, 0, 0, 16'hFFFF, 16, 0, 0));
        run_table();
        for (int i = 0; i < 16; i++)
            chk($sformatf("fill_addr%0d", i), 32'(slot_addr(i)), 32'((8 + i) % 32));

        // Issue from a full queue while dispatching: dispatch rejected, slot 2 reused next cycle.
        vecs.push_back(mk("iss10_full_disp", 0, 1, 1, 1, 2, 1, 24, 0, 0, 1, 10, 16'hFFFB, 15, 1, 0));
        vecs.push_back(mk("disp_slot2", 0, 1, 1, 1, 2, 1, 24, 0, 0, 0, 0, 16'hFFFF, 16, 0, 0));
        run_table();
        chk("slot2_addr", 32'(slot_addr(2)), 32'd24);

        vecs.push_back(mk("miss_absent", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 16'hFFFF, 16, 0, 1));
        vecs.push_back(mk("miss_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 16, 0, 0));
        vecs.push_back(mk("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
        vecs.push_back(mk("disp_wait9", 0, 1, 9, 0, 0, 0, 3, 0, 0, 0, 0, 16'h0000, 1, 1, 0));
        vecs.push_back(mk("disp_bypass12", 0, 1, 12, 0, 0, 0, 4, 1, 12, 0, 0, 16'h0002, 2, 1, 0));
        vecs.push_back(mk("miss_notrdy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h0002, 2, 1, 1));
        vecs.push_back(mk("wb_tag0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0002, 2, 1, 0));
        vecs.push_back(mk("wake9", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 16'h0003, 2, 1, 0));
        vecs.push_back(mk("iss4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 16'h0001, 1, 1, 0));
        vecs.push_back(mk("alloc_iss_wb", 0, 1, 1, 1, 2, 1, 5, 1, 7, 1, 3, 16'h0002, 1, 1, 0));
        vecs.push_back(mk("disp6", 0, 1, 7, 0, 7, 0, 6, 0, 0, 0, 0, 16'h0002, 2, 1, 0));
        vecs.push_back(mk("disp11", 0, 1, 13, 0, 7, 0, 11, 0, 0, 0, 0, 16'h0002, 3, 1, 0));
        vecs.push_back(mk("wake7", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0003, 3, 1, 0));
        vecs.push_back(mk("wake13", 0, 0, 0, 0, 0, 0, 0, 1, 13, 0, 0, 16'h0007, 3, 1, 0));
        vecs.push_back(mk("disp14", 0, 1, 1, 1, 2, 1, 14, 0, 0, 0, 0, 16'h000F, 4, 1, 0));
        vecs.push_back(mk("disp15", 0, 1, 1, 1, 2, 1, 15, 0, 0, 0, 0, 16'h001F, 5, 1, 0));
        vecs.push_back(mk("rst_busy", 1, 1, 1, 1, 2, 1, 16, 1, 9, 1, 5, 16'h0000, 0, 1, 0));
        vecs.push_back(mk("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0));
        run_table();
        chk("rst_addr_vec", 32'(addr_vec != '0), 32'd0);

        vecs.push_back(mk("disp20", 0, 1, 1, 1, 2, 1, 20, 0, 0, 0, 0, 16'h0001, 1, 1, 0));
        run_table();
        chk("slot0_addr", 32'(slot_addr(0)), 32'd20);
        chk("slot1_addr_masked", 32'(slot_addr(1)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
